// File: rtl/swc_page_bitmap_alloc.sv
// rtl/swc_page_bitmap_alloc.sv - free-page bitmap allocator with per-page use counts
// Lowest-free-page selection comes from swc_prio_encoder, registered into enc_q every cycle.

module swc_prio_encoder #(
  parameter int g_num_inputs  = 36,
  parameter int g_output_bits = 6
) (
  input  logic [g_num_inputs-1:0]  in_i,
  output logic [g_output_bits-1:0] out_o
);

  // Scan from the top so the last hit is the lowest set bit.
  always_comb begin
    out_o = '0;
    for (int i = g_num_inputs - 1; i >= 0; i--) begin
      if (in_i[i]) out_o = g_output_bits'(i);
    end
  end

endmodule

module swc_page_bitmap_alloc #(
  parameter int g_num_pages      = 36,
  parameter int g_page_addr_bits = 6,
  parameter int g_usecnt_bits    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alloc_i,
  input  logic [g_usecnt_bits-1:0]    usecnt_i,
  input  logic                        free_i,
  input  logic [g_page_addr_bits-1:0] free_pgaddr_i,
  output logic                        done_o,
  output logic [g_page_addr_bits-1:0] pgaddr_o,
  output logic                        nomem_o,
  output logic                        double_free_o,
  output logic [g_page_addr_bits:0]   free_count_o,
  output logic                        idle_o
);

  localparam logic [g_page_addr_bits:0] NUM_PAGES_W = (g_page_addr_bits + 1)'(g_num_pages);
  localparam logic [g_usecnt_bits-1:0]  CNT_ONE     = g_usecnt_bits'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    FREE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [g_num_pages-1:0]      bitmap;
  logic [g_usecnt_bits-1:0]    usecnt [g_num_pages];
  logic [g_page_addr_bits-1:0] enc_d, enc_q;
  logic [g_page_addr_bits-1:0] pgaddr_q;
  logic [g_page_addr_bits:0]   free_count_q;
  logic                        nomem_q, dfree_q;
  logic                        addr_ok;
  logic [g_usecnt_bits-1:0]    cur_cnt;
  logic [g_usecnt_bits-1:0]    init_cnt;

  swc_prio_encoder #(
    .g_num_inputs  (g_num_pages),
    .g_output_bits (g_page_addr_bits)
  ) u_enc (
    .in_i  (bitmap),
    .out_o (enc_d)
  );

  // Out-of-range release addresses read as count 0 so they fall into the double-free path.
  always_comb begin
    addr_ok  = ({1'b0, free_pgaddr_i} < NUM_PAGES_W);
    cur_cnt  = addr_ok ? usecnt[free_pgaddr_i] : '0;
    init_cnt = (usecnt_i == '0) ? CNT_ONE : usecnt_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (alloc_i)     state_d = ALLOC;
        else if (free_i) state_d = FREE;
      end
      ALLOC:   state_d = DONE;
      FREE:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitmap       <= '1;
      for (int i = 0; i < g_num_pages; i++) usecnt[i] <= '0;
      enc_q        <= '0;
      pgaddr_q     <= '0;
      free_count_q <= NUM_PAGES_W;
      nomem_q      <= 1'b0;
      dfree_q      <= 1'b0;
    end else begin
      enc_q <= enc_d;
      case (state_q)
        ALLOC: begin
          if (free_count_q == '0) begin
            nomem_q <= 1'b1;
          end else begin
            bitmap[enc_q] <= 1'b0;
            usecnt[enc_q] <= init_cnt;
            pgaddr_q      <= enc_q;
            free_count_q  <= free_count_q - 1'b1;
          end
        end
        FREE: begin
          if (cur_cnt == '0) begin
            dfree_q <= 1'b1;
          end else if (cur_cnt > CNT_ONE) begin
            usecnt[free_pgaddr_i] <= cur_cnt - CNT_ONE;
          end else begin
            usecnt[free_pgaddr_i] <= '0;
            bitmap[free_pgaddr_i] <= 1'b1;
            free_count_q          <= free_count_q + 1'b1;
          end
        end
        DONE: begin
          nomem_q <= 1'b0;
          dfree_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign done_o        = (state_q == DONE);
  assign idle_o        = (state_q == IDLE);
  assign pgaddr_o      = pgaddr_q;
  assign nomem_o       = nomem_q;
  assign double_free_o = dfree_q;
  assign free_count_o  = free_count_q;

endmodule
